bp_be_issue_sequencer: RTL and testbench
========================================

// Module: bp_be_issue_sequencer
// PURPOSE
// Control sequencer for the BE issue queue. Converts dispatch, commit, replay and
// flush events into the queue's one-hot command strobes (read/deq/roll/clr/suppress).
// Tracks dispatched-but-uncommitted entries (checkpoint-to-read distance) and holds
// fetch suppression across a flush until the FE acknowledges the redirect.
// PARAMETERS
// inflight_els_p        8  max entries dispatched but not yet committed
// compressed_support_p  0  1: honour skip (half-instruction) qualifiers on read/deq
// PORTS
// clk_i            in   1    clock
// reset_n_i        in   1    reset; synchronous, active-low
// issue_v_i        in   1    issue queue presents a valid issue packet
// dispatch_v_i     in   1    dispatcher wants to consume the current issue packet
// dispatch_skip_i  in   1    consumed packet spans a full 32b slot (compressed mode)
// commit_v_i       in   1    oldest in-flight entry committed
// commit_skip_i    in   1    committed entry spans a full 32b slot (compressed mode)
// replay_v_i       in   1    rewind read pointer to checkpoint (roll)
// flush_v_i        in   1    discard all queue contents (clear)
// redirect_ack_i   in   1    FE accepted redirect; end suppression
// read_v_o         out  1    issue queue read (advance read ptr)
// read_skip_o      out  1    read advances by full slot
// deq_v_o          out  1    issue queue dequeue (advance checkpoint)
// deq_skip_o       out  1    dequeue advances by full slot
// roll_v_o         out  1    issue queue roll
// clr_v_o          out  1    issue queue clear
// suppress_v_o     out  1    block enqueue and issue-valid
// dispatch_ready_o out  1    dispatch may be accepted this cycle
// inflight_cnt_o   out  $clog2(inflight_els_p+1)  in-flight count (registered)
// underflow_o      out  1    sticky: commit seen with zero in-flight
// BEHAVIOUR
// - Reset: while reset_n_i=0 every output is driven 0; at the clock edge state<=RUN,
//   cnt<=0, underflow<=0. Reset asserted mid-flush discards WAIT; after release, RUN.
// - States: RUN, ROLL (exactly 1 cycle), WAIT (suppressed, waiting for redirect_ack_i).
// - All command outputs are combinational from inputs + state; count/state registered.
// - Priority per cycle: flush > replay > commit/dispatch.
// - flush_v_i (any state): clr_v_o=1, suppress_v_o=1, read/deq/roll=0, cnt<=0,
//   next=WAIT. A flush in WAIT restarts WAIT. redirect_ack_i in the flush cycle is ignored.
// - WAIT: suppress_v_o=1, read/deq/roll=0, replay and commit ignored (no count change,
//   no underflow); redirect_ack_i=1 -> next RUN (suppress drops next cycle).
// - RUN, replay_v_i: roll_v_o=1, read_v_o=0, deq_v_o=commit_v_i&(cnt!=0) (queue folds
//   deq into roll), cnt<=0, next=ROLL.
// - ROLL: dispatch_ready_o=0, read_v_o=0; commit ignored (cnt already 0); next=RUN.
//   replay in ROLL: another roll, stays ROLL. flush in ROLL: handled as above.
// - RUN normal: deq_v_o=commit_v_i&(cnt!=0); dispatch_ready_o=issue_v_i&
//   (cnt<inflight_els_p | deq_v_o) (same-cycle commit frees a slot);
//   read_v_o=dispatch_v_i&dispatch_ready_o.
//   cnt<=cnt+read_v_o-deq_v_o; cnt never exceeds inflight_els_p nor wraps below 0.
// - commit_v_i with cnt==0 outside WAIT/ROLL: deq_v_o=0, underflow<=1 (sticky to reset).
// - Skip: read_skip_o=read_v_o&dispatch_skip_i&compressed_support_p; deq_skip_o
//   likewise with commit_skip_i. compressed_support_p=0 -> skips tied 0.
// - Count tracks entries, not halfwords; skip does not change count arithmetic.
// - Invariant: at most one of {clr, roll} per cycle; clr excludes all other commands.
// TESTING
// - Reset release, issue_v=1, dispatch_v=1 for 3 cycles -> read_v_o=1 x3, cnt=3.
// - inflight_els_p=8, cnt=8, dispatch_v=1 no commit -> read_v_o=0; add commit_v same
//   cycle -> read_v_o=1, deq_v_o=1, cnt stays 8.
// - cnt=5, replay_v+commit_v -> roll_v_o=1, deq_v_o=1, cnt=0; next cycle ROLL,
//   dispatch_v=1 -> read_v_o=0; cycle after -> read_v_o=1.
// - flush_v with dispatch_v,replay_v -> clr_v_o=1 only + suppress; suppress held 4
//   cycles until redirect_ack_i=1; suppress_v_o=0 the following cycle.
// - commit_v at cnt=0 in RUN -> deq_v_o=0, underflow_o=1 and stays 1; 0 after reset.
// - compressed_support_p=1, dispatch_skip=1 -> read_skip_o=1; with param 0 -> 0.

Source files
------------

// File: rtl/bp_be_issue_sequencer_if.sv
// Handshake bundle between the BE issue queue/dispatcher and the issue sequencer.
// Signal suffixes are relative to the sequencer (slave side).
interface bp_be_issue_sequencer_if #(
  parameter int inflight_els_p = 8
);
  localparam int cnt_width_lp = $clog2(inflight_els_p + 1);

  logic                    issue_v_i;
  logic                    dispatch_v_i;
  logic                    dispatch_skip_i;
  logic                    commit_v_i;
  logic                    commit_skip_i;
  logic                    replay_v_i;
  logic                    flush_v_i;
  logic                    redirect_ack_i;

  logic                    read_v_o;
  logic                    read_skip_o;
  logic                    deq_v_o;
  logic                    deq_skip_o;
  logic                    roll_v_o;
  logic                    clr_v_o;
  logic                    suppress_v_o;
  logic                    dispatch_ready_o;
  logic [cnt_width_lp-1:0] inflight_cnt_o;
  logic                    underflow_o;

  modport master (
    output issue_v_i, dispatch_v_i, dispatch_skip_i, commit_v_i, commit_skip_i,
           replay_v_i, flush_v_i, redirect_ack_i,
    input  read_v_o, read_skip_o, deq_v_o, deq_skip_o, roll_v_o, clr_v_o,
           suppress_v_o, dispatch_ready_o, inflight_cnt_o, underflow_o
  );

  modport slave (
    input  issue_v_i, dispatch_v_i, dispatch_skip_i, commit_v_i, commit_skip_i,
           replay_v_i, flush_v_i, redirect_ack_i,
    output read_v_o, read_skip_o, deq_v_o, deq_skip_o, roll_v_o, clr_v_o,
           suppress_v_o, dispatch_ready_o, inflight_cnt_o, underflow_o
  );
endinterface

// File: rtl/bp_be_issue_sequencer.sv
// BE issue queue sequencer: turns dispatch/commit/replay/flush events into one-hot
// queue command strobes and tracks the dispatched-but-uncommitted entry count.
//
// state   | meaning
// RUN     | normal dispatch/commit operation
// ROLL    | one cycle after a roll; queue read pointer is settling, no reads
// WAIT    | post-flush, fetch suppressed until FE acknowledges the redirect
module bp_be_issue_sequencer #(
  parameter int inflight_els_p       = 8,
  parameter bit compressed_support_p = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bp_be_issue_sequencer_if.slave   seq_if
);
  localparam int cnt_width_lp = $clog2(inflight_els_p + 1);
  localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(inflight_els_p);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ROLL = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    underflow_q, underflow_d;

  logic read_v, deq_v, roll_v, clr_v, suppress_v, dispatch_ready;
  logic cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    underflow_d    = underflow_q;
    read_v         = 1'b0;
    deq_v          = 1'b0;
    roll_v         = 1'b0;
    clr_v          = 1'b0;
    suppress_v     = 1'b0;
    dispatch_ready = 1'b0;

    if (seq_if.flush_v_i) begin
      // Flush wins over everything, including a same-cycle redirect ack.
      clr_v      = 1'b1;
      suppress_v = 1'b1;
      cnt_d      = '0;
      state_d    = ST_WAIT;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          suppress_v = 1'b1;
          if (seq_if.redirect_ack_i) state_d = ST_RUN;
        end
        ST_ROLL: begin
          state_d = ST_RUN;
          if (seq_if.replay_v_i) begin
            roll_v  = 1'b1;
            cnt_d   = '0;
            state_d = ST_ROLL;
          end
        end
        default: begin
          deq_v = seq_if.commit_v_i & ~cnt_zero;
          if (seq_if.commit_v_i && cnt_zero) underflow_d = 1'b1;
          if (seq_if.replay_v_i) begin
            // The queue folds a same-cycle dequeue into the roll.
            roll_v  = 1'b1;
            cnt_d   = '0;
            state_d = ST_ROLL;
          end else begin
            // A same-cycle commit frees a slot, so a full window can still dispatch.
            dispatch_ready = seq_if.issue_v_i & ((cnt_q < cnt_max_lp) | deq_v);
            read_v         = seq_if.dispatch_v_i & dispatch_ready;
            cnt_d          = cnt_q + cnt_width_lp'(read_v) - cnt_width_lp'(deq_v);
          end
        end
      endcase
    end
  end

  assign seq_if.read_v_o         = reset_n_i & read_v;
  assign seq_if.read_skip_o      = reset_n_i & read_v & seq_if.dispatch_skip_i & compressed_support_p;
  assign seq_if.deq_v_o          = reset_n_i & deq_v;
  assign seq_if.deq_skip_o       = reset_n_i & deq_v & seq_if.commit_skip_i & compressed_support_p;
  assign seq_if.roll_v_o         = reset_n_i & roll_v;
  assign seq_if.clr_v_o          = reset_n_i & clr_v;
  assign seq_if.suppress_v_o     = reset_n_i & suppress_v;
  assign seq_if.dispatch_ready_o = reset_n_i & dispatch_ready;
  assign seq_if.inflight_cnt_o   = reset_n_i ? cnt_q : '0;
  assign seq_if.underflow_o      = reset_n_i & underflow_q;
endmodule

// File: tb/tb_bp_be_issue_sequencer.sv
// Directed-vector bench for bp_be_issue_sequencer; a second instance with
// compressed support enabled shares the stimulus to check the skip qualifiers.
module tb_bp_be_issue_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bp_be_issue_sequencer_if #(.inflight_els_p(8)) bus0 ();
  bp_be_issue_sequencer_if #(.inflight_els_p(8)) bus1 ();

  bp_be_issue_sequencer #(.inflight_els_p(8), .compressed_support_p(1'b0)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .seq_if(bus0)
  );
  bp_be_issue_sequencer #(.inflight_els_p(8), .compressed_support_p(1'b1)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .seq_if(bus1)
  );

  assign bus1.issue_v_i       = bus0.issue_v_i;
  assign bus1.dispatch_v_i    = bus0.dispatch_v_i;
  assign bus1.dispatch_skip_i = bus0.dispatch_skip_i;
  assign bus1.commit_v_i      = bus0.commit_v_i;
  assign bus1.commit_skip_i   = bus0.commit_skip_i;
  assign bus1.replay_v_i      = bus0.replay_v_i;
  assign bus1.flush_v_i       = bus0.flush_v_i;
  assign bus1.redirect_ack_i  = bus0.redirect_ack_i;

  // in:    {issue, dispatch, dskip, commit, cskip, replay, flush, ack}
  // flags: {read, deq, roll, clr, suppress, ready}
  // cnt/uf are the registered values visible during the cycle.
  typedef struct packed {
    logic       rst_n;
    logic [7:0] in;
    logic [5:0] flags;
    logic [3:0] cnt;
    logic       uf;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic r, input logic [7:0] i, input logic [5:0] f,
                              input logic [3:0] c, input logic u);
    vec_t v;
    v.rst_n = r; v.in = i; v.flags = f; v.cnt = c; v.uf = u;
    return v;
  endfunction

  // Called right after a rising edge; checks combinational outputs before the next edge.
  task automatic apply(input vec_t v, input string tag);
    logic [14:0] exp_b, act_b;
    logic rs1, ds1;
    rst_n                = v.rst_n;
    bus0.issue_v_i       = v.in[7];
    bus0.dispatch_v_i    = v.in[6];
    bus0.dispatch_skip_i = v.in[5];
    bus0.commit_v_i      = v.in[4];
    bus0.commit_skip_i   = v.in[3];
    bus0.replay_v_i      = v.in[2];
    bus0.flush_v_i       = v.in[1];
    bus0.redirect_ack_i  = v.in[0];
    #3;
    rs1   = v.flags[5] & v.in[5];
    ds1   = v.flags[4] & v.in[3];
    exp_b = {v.flags, v.cnt, v.uf, 2'b00, rs1, ds1};
    act_b = {bus0.read_v_o, bus0.deq_v_o, bus0.roll_v_o, bus0.clr_v_o, bus0.suppress_v_o,
             bus0.dispatch_ready_o, bus0.inflight_cnt_o, bus0.underflow_o,
             bus0.read_skip_o, bus0.deq_skip_o, bus1.read_skip_o, bus1.deq_skip_o};
    n_tests++;
    if (act_b !== exp_b) begin
      n_fail++;
      $display("FAIL %s: got rd/dq/rl/cl/sp/rdy=%b cnt=%0d uf=%b skips=%b, want %b cnt=%0d uf=%b skips=%b",
               tag, act_b[14:9], act_b[8:5], act_b[4], act_b[3:0],
               exp_b[14:9], exp_b[8:5], exp_b[4], exp_b[3:0]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.issue_v_i = 0; bus0.dispatch_v_i = 0; bus0.dispatch_skip_i = 0;
    bus0.commit_v_i = 0; bus0.commit_skip_i = 0; bus0.replay_v_i = 0;
    bus0.flush_v_i = 0; bus0.redirect_ack_i = 0;

    // Reset with busy inputs: everything must read 0.
    vq.push_back(mk(0, 8'b1101_1110, 6'b000000, 0, 0));
    vq.push_back(mk(0, 8'b1111_1111, 6'b000000, 0, 0));
    // Three dispatches, one with skip.
    vq.push_back(mk(1, 8'b1100_0000, 6'b100001, 0, 0));
    vq.push_back(mk(1, 8'b1110_0000, 6'b100001, 1, 0));
    vq.push_back(mk(1, 8'b1100_0000, 6'b100001, 2, 0));
    vq.push_back(mk(1, 8'b0000_0000, 6'b000000, 3, 0));
    // Fill to the limit.
    for (int c = 3; c < 8; c++) vq.push_back(mk(1, 8'b1100_0000, 6'b100001, 4'(c), 0));
    // Full: dispatch blocked, then same-cycle commit lets it through (cskip on).
    vq.push_back(mk(1, 8'b1100_0000, 6'b000000, 8, 0));
    vq.push_back(mk(1, 8'b1101_1000, 6'b110001, 8, 0));
    vq.push_back(mk(1, 8'b0001_0000, 6'b010000, 8, 0));
    vq.push_back(mk(1, 8'b0001_0000, 6'b010000, 7, 0));
    vq.push_back(mk(1, 8'b0001_0000, 6'b010000, 6, 0));
    // cnt=5: replay + commit (+ dispatch attempt) -> roll, deq, no read.
    vq.push_back(mk(1, 8'b1101_0100, 6'b011000, 5, 0));
    // ROLL: no read, commit ignored.
    vq.push_back(mk(1, 8'b1101_0000, 6'b000000, 0, 0));
    vq.push_back(mk(1, 8'b1100_0000, 6'b100001, 0, 0));
    // Flush with dispatch and replay: clear + suppress only.
    vq.push_back(mk(1, 8'b1100_0110, 6'b000110, 1, 0));
    vq.push_back(mk(1, 8'b1101_0100, 6'b000010, 0, 0));
    vq.push_back(mk(1, 8'b0000_0000, 6'b000010, 0, 0));
    vq.push_back(mk(1, 8'b0000_0001, 6'b000010, 0, 0));
    vq.push_back(mk(1, 8'b0000_0000, 6'b000000, 0, 0));
    // Underflow: commit at zero, sticky afterwards.
    vq.push_back(mk(1, 8'b0001_0000, 6'b000000, 0, 0));
    vq.push_back(mk(1, 8'b0000_0000, 6'b000000, 0, 1));
    // Flush with ack in same cycle: ack ignored, stays WAIT.
    vq.push_back(mk(1, 8'b0000_0011, 6'b000110, 0, 1));
    vq.push_back(mk(1, 8'b0000_0000, 6'b000010, 0, 1));
    vq.push_back(mk(1, 8'b0000_0010, 6'b000110, 0, 1));
    vq.push_back(mk(1, 8'b0000_0001, 6'b000010, 0, 1));
    vq.push_back(mk(1, 8'b0000_0000, 6'b000000, 0, 1));
    // Replay in RUN, then replay again in ROLL.
    vq.push_back(mk(1, 8'b0000_0100, 6'b001000, 0, 1));
    vq.push_back(mk(1, 8'b1100_0100, 6'b001000, 0, 1));
    vq.push_back(mk(1, 8'b1100_0000, 6'b000000, 0, 1));
    vq.push_back(mk(1, 8'b1100_0000, 6'b100001, 0, 1));

    @(posedge clk);
    #1;
    foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

    // Reset asserted right after a flush: WAIT discarded, RUN after release.
    apply(mk(1, 8'b0000_0010, 6'b000110, 1, 1), "pre_reset_flush");
    apply(mk(0, 8'b1100_0010, 6'b000000, 0, 0), "reset_in_wait");
    apply(mk(1, 8'b0000_0000, 6'b000000, 0, 0), "post_reset_idle");
    apply(mk(1, 8'b1110_0000, 6'b100001, 0, 0), "post_reset_dispatch");
    apply(mk(1, 8'b0001_1000, 6'b010000, 1, 0), "post_reset_commit");
    apply(mk(1, 8'b0000_0000, 6'b000000, 0, 0), "post_reset_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
